// File: rtl/al4s3b_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : al4s3b_cnt_pkg
// Purpose  : Shared register map, bit positions and types for the AL4S3B
//            Wishbone counter block.
// Revision : 1.0 - initial release
// ============================================================================
package al4s3b_cnt_pkg;

    // Word addresses of the register map
    localparam int unsigned REG_ID       = 0;
    localparam int unsigned REG_REV      = 1;
    localparam int unsigned REG_SET_RST  = 2;
    localparam int unsigned REG_EN       = 3;
    localparam int unsigned REG_ERR_STS  = 4;
    localparam int unsigned REG_CNT_VAL  = 5;
    localparam int unsigned REG_PRESCALE = 6;

    // EN register fields
    localparam int unsigned EN_BIT  = 0;
    localparam int unsigned DIR_BIT = 1;

    // SET_RST register fields
    localparam int unsigned SET_RST_CLR_BIT  = 0;
    localparam int unsigned SET_RST_LOAD_BIT = 1;

    // ERR_STS register fields
    localparam int unsigned ERR_OVF_BIT = 0;
    localparam int unsigned ERR_UNF_BIT = 1;

    // Read data returned for undecoded addresses
    localparam logic [31:0] DFLT_READ_VALUE = 32'hBAD_FAB_AC;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } cnt_dir_t;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/al4s3b_cnt_core.sv
`default_nettype none
// ============================================================================
// Module   : al4s3b_cnt_core
// Purpose  : 16-bit up/down counter with clear/load, wrap detection and an
//            optional 8-bit prescaler (enabled by AL4S3B_CNT_PRESCALE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module al4s3b_cnt_core
    import al4s3b_cnt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  cnt_dir_t    dir,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
`ifdef AL4S3B_CNT_PRESCALE_EN
    input  logic [7:0]  prescale,
    input  logic        div_clr,
`endif
    output logic [15:0] count,
    output logic        ovf_pulse,
    output logic        unf_pulse
);

    logic tick;
    logic step;

`ifdef AL4S3B_CNT_PRESCALE_EN
    logic [7:0] div;

    assign tick = (div == prescale);

    // Divider: counts enabled clocks, restarts after each tick or SET_RST write
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= 8'h00;
        else if (div_clr || !enable || tick)
            div <= 8'h00;
        else
            div <= div + 8'd1;
    end
`else
    assign tick = 1'b1;
`endif

    // Clear/load take the edge, so no step happens alongside them
    assign step      = enable & tick & ~clr & ~load;
    assign ovf_pulse = step & (dir == UP)   & (count == 16'hFFFF);
    assign unf_pulse = step & (dir == DOWN) & (count == 16'h0000);

    // Counter: clear beats load, load beats step; arithmetic wraps mod 2^16
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 16'h0000;
        else if (clr)
            count <= 16'h0000;
        else if (load)
            count <= load_val;
        else if (step)
            count <= (dir == DOWN) ? count - 16'd1 : count + 16'd1;
    end

endmodule
`default_nettype wire

// File: rtl/al4s3b_cnt_regs.sv
`default_nettype none
// ============================================================================
// Module   : al4s3b_cnt_regs
// Purpose  : Wishbone slave register file driving the AL4S3B fabric counter.
//            Optional PRESCALE register enabled by AL4S3B_CNT_PRESCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module al4s3b_cnt_regs
    import al4s3b_cnt_pkg::*;
#(
    parameter int          ADDRWIDTH          = 7,
    parameter logic [15:0] AL4S3B_DEVICE_ID   = 16'h0,
    parameter logic [31:0] AL4S3B_REV_LEVEL   = 32'h0,
    parameter logic [31:0] DEFAULT_READ_VALUE = DFLT_READ_VALUE
)(
    input  logic                 WB_CLK,
    input  logic                 WB_RST,
    input  logic [ADDRWIDTH-1:0] WBs_ADR,
    input  logic                 WBs_CYC,
    input  logic                 WBs_STB,
    input  logic                 WBs_WE,
    input  logic [3:0]           WBs_BYTE_STB,
    input  logic [31:0]          WBs_WR_DAT,
    output logic [31:0]          WBs_RD_DAT,
    output logic                 WBs_ACK,
    output logic [15:0]          count,
    output logic [31:0]          Device_ID
);

    localparam logic [ADDRWIDTH-1:0] A_ID      = ADDRWIDTH'(REG_ID);
    localparam logic [ADDRWIDTH-1:0] A_REV     = ADDRWIDTH'(REG_REV);
    localparam logic [ADDRWIDTH-1:0] A_SET_RST = ADDRWIDTH'(REG_SET_RST);
    localparam logic [ADDRWIDTH-1:0] A_EN      = ADDRWIDTH'(REG_EN);
    localparam logic [ADDRWIDTH-1:0] A_ERR_STS = ADDRWIDTH'(REG_ERR_STS);
    localparam logic [ADDRWIDTH-1:0] A_CNT_VAL = ADDRWIDTH'(REG_CNT_VAL);
`ifdef AL4S3B_CNT_PRESCALE_EN
    localparam logic [ADDRWIDTH-1:0] A_PRE     = ADDRWIDTH'(REG_PRESCALE);
`endif

    bus_state_t  state;
    logic        bus_req;
    logic        wr_commit;
    logic        set_rst_wr;
    logic        clr;
    logic        load;
    logic [1:0]  en_q;
    logic [1:0]  err_q;
    logic [1:0]  err_w1c;
    logic        ovf_pulse;
    logic        unf_pulse;
    logic [31:0] rd_mux;
    logic        unused_bits;
`ifdef AL4S3B_CNT_PRESCALE_EN
    logic [7:0]  prescale_q;
`endif

    assign Device_ID = {12'h0, AL4S3B_DEVICE_ID, 4'h0};

    // A request is accepted only from IDLE; the write commits on that edge
    assign bus_req    = WBs_CYC & WBs_STB & ~WBs_ACK & (state == BUS_IDLE);
    assign wr_commit  = bus_req & WBs_WE;
    assign set_rst_wr = wr_commit & (WBs_ADR == A_SET_RST);

    // Load needs the data byte holding the command bit and both upper bytes
    assign clr  = set_rst_wr & WBs_BYTE_STB[0] & WBs_WR_DAT[SET_RST_CLR_BIT];
    assign load = set_rst_wr & WBs_BYTE_STB[0] & (&WBs_BYTE_STB[3:2])
                & WBs_WR_DAT[SET_RST_LOAD_BIT];

    assign err_w1c = {2{wr_commit & (WBs_ADR == A_ERR_STS) & WBs_BYTE_STB[0]}}
                   & WBs_WR_DAT[1:0];

    assign unused_bits = ^{WBs_BYTE_STB[1], WBs_WR_DAT[15:2]};

    al4s3b_cnt_core u_core (
        .clk       (WB_CLK),
        .rst       (WB_RST),
        .enable    (en_q[EN_BIT]),
        .dir       (cnt_dir_t'(en_q[DIR_BIT])),
        .clr       (clr),
        .load      (load),
        .load_val  (WBs_WR_DAT[31:16]),
`ifdef AL4S3B_CNT_PRESCALE_EN
        .prescale  (prescale_q),
        .div_clr   (set_rst_wr),
`endif
        .count     (count),
        .ovf_pulse (ovf_pulse),
        .unf_pulse (unf_pulse)
    );

    // Read mux: counter value is the pre-step value at the sampling edge
    always_comb begin
        rd_mux = DEFAULT_READ_VALUE;
        case (WBs_ADR)
            A_ID:      rd_mux = {16'h0, AL4S3B_DEVICE_ID};
            A_REV:     rd_mux = AL4S3B_REV_LEVEL;
            A_SET_RST: rd_mux = 32'h0;
            A_EN:      rd_mux = {30'h0, en_q};
            A_ERR_STS: rd_mux = {30'h0, err_q};
            A_CNT_VAL: rd_mux = {16'h0, count};
`ifdef AL4S3B_CNT_PRESCALE_EN
            A_PRE:     rd_mux = {24'h0, prescale_q};
`endif
            default:   rd_mux = DEFAULT_READ_VALUE;
        endcase
    end

    // Bus handshake: one-cycle ACK with read data captured on the request edge
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            state      <= BUS_IDLE;
            WBs_ACK    <= 1'b0;
            WBs_RD_DAT <= 32'h0;
        end else begin
            case (state)
                BUS_IDLE: begin
                    if (bus_req) begin
                        state      <= BUS_ACK;
                        WBs_ACK    <= 1'b1;
                        WBs_RD_DAT <= rd_mux;
                    end
                end
                BUS_ACK: begin
                    state   <= BUS_IDLE;
                    WBs_ACK <= 1'b0;
                end
            endcase
        end
    end

    // Control/status registers; a new wrap event beats a coincident W1C
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            en_q  <= 2'b00;
            err_q <= 2'b00;
        end else begin
            if (wr_commit && (WBs_ADR == A_EN) && WBs_BYTE_STB[0])
                en_q <= WBs_WR_DAT[1:0];
            err_q[ERR_OVF_BIT] <= ovf_pulse | (err_q[ERR_OVF_BIT] & ~err_w1c[ERR_OVF_BIT]);
            err_q[ERR_UNF_BIT] <= unf_pulse | (err_q[ERR_UNF_BIT] & ~err_w1c[ERR_UNF_BIT]);
        end
    end

`ifdef AL4S3B_CNT_PRESCALE_EN
    // Prescale divisor register
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST)
            prescale_q <= 8'h00;
        else if (wr_commit && (WBs_ADR == A_PRE) && WBs_BYTE_STB[0])
            prescale_q <= WBs_WR_DAT[7:0];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_al4s3b_cnt_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_al4s3b_cnt_regs
// Purpose  : Self-checking bench for al4s3b_cnt_regs; read data is checked
//            through an expected-value queue popped on each read ACK.
// Revision : 1.0 - initial release
// ============================================================================
module tb_al4s3b_cnt_regs;

    localparam logic [15:0] DEV_ID   = 16'h4C53;
    localparam logic [31:0] REV_LVL  = 32'h0001_0203;
    localparam logic [31:0] DFLT_RD  = 32'hBADF_ABAC;

    logic        clk;
    logic        rst;
    logic [6:0]  adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  bs;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic [15:0] count;
    logic [31:0] dev_id;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    al4s3b_cnt_regs #(
        .ADDRWIDTH          (7),
        .AL4S3B_DEVICE_ID   (DEV_ID),
        .AL4S3B_REV_LEVEL   (REV_LVL),
        .DEFAULT_READ_VALUE (DFLT_RD)
    ) dut (
        .WB_CLK       (clk),
        .WB_RST       (rst),
        .WBs_ADR      (adr),
        .WBs_CYC      (cyc),
        .WBs_STB      (stb),
        .WBs_WE       (we),
        .WBs_BYTE_STB (bs),
        .WBs_WR_DAT   (wdat),
        .WBs_RD_DAT   (rdat),
        .WBs_ACK      (ack),
        .count        (count),
        .Device_ID    (dev_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Read data scoreboard: pop one expectation per read ACK
    always @(posedge clk) begin
        #1;
        if (ack && !we) begin
            if (exp_q.size() == 0)
                check("sb_spurious_ack", 32'h1, 32'h0);
            else
                check(tag_q.pop_front(), rdat, exp_q.pop_front());
        end
    end

    task automatic bus_cycle(input logic w, input logic [6:0] a, input logic [31:0] d,
                             input logic [3:0] b);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; bs = b;
        @(posedge clk); #1;
        check("ack_latency", {31'h0, ack}, 32'h1);
        n = 0;
        while (!ack && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ack) check("ack_timeout", 32'h0, 32'h1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] b);
        bus_cycle(1'b1, a, d, b);
    endtask

    task automatic bus_read(input logic [6:0] a, input logic [31:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        bus_cycle(1'b0, a, 32'h0, 4'hF);
    endtask

    task automatic tick_check(input string t, input logic [15:0] e);
        @(posedge clk); #1;
        check(t, {16'h0, count}, {16'h0, e});
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; bs = 4'h0; wdat = '0;
        #22;
        check("rst_ack",    {31'h0, ack}, 32'h0);
        check("rst_rdat",   rdat, 32'h0);
        check("rst_count",  {16'h0, count}, 32'h0);
        check("device_id",  dev_id, {12'h0, DEV_ID, 4'h0});
        @(negedge clk);
        rst = 1'b0;

        // Identification and default reads
        bus_read(7'd0, {16'h0, DEV_ID}, "rd_id");
        bus_read(7'd1, REV_LVL,         "rd_rev");
        bus_read(7'd5, 32'h0,           "rd_cnt_rst");
        bus_read(7'd7, DFLT_RD,         "rd_undecoded");
        bus_read(7'd2, 32'h0,           "rd_set_rst");
        @(posedge clk); #1;
        check("ack_single_cycle", {31'h0, ack}, 32'h0);

        // Load then count up for ten clocks
        bus_write(7'd2, 32'h1234_0002, 4'hF);
        bus_write(7'd3, 32'h1, 4'hF);
        check("en_edge_old_enable", {16'h0, count}, 32'h1234);
        tick_check("up_step1", 16'h1235);
        repeat (8) @(posedge clk);
        tick_check("up_step10", 16'h123E);
        bus_read(7'd5, 32'h0000_123E, "rd_cnt_prestep");
        bus_write(7'd3, 32'h0, 4'hF);
        tick_check("stop_count", 16'h1241);

        // Overflow wrap and W1C
        bus_write(7'd2, 32'hFFFE_0002, 4'hF);
        bus_write(7'd3, 32'h1, 4'hF);
        tick_check("ovf_ffff", 16'hFFFF);
        tick_check("ovf_0000", 16'h0000);
        tick_check("ovf_0001", 16'h0001);
        bus_write(7'd3, 32'h0, 4'hF);
        bus_read(7'd4, 32'h1, "rd_err_ovf");
        bus_write(7'd4, 32'h1, 4'hF);
        bus_read(7'd4, 32'h0, "rd_err_ovf_clr");

        // Underflow wrap, then W1C coincident with a new underflow
        bus_write(7'd2, 32'h0000_0002, 4'hF);
        bus_write(7'd3, 32'h3, 4'hF);
        tick_check("unf_ffff", 16'hFFFF);
        bus_read(7'd4, 32'h2, "rd_err_unf");
        bus_read(7'd3, 32'h3, "rd_en");
        bus_write(7'd2, 32'h0001_0002, 4'hF);
        bus_write(7'd4, 32'h2, 4'hF);
        check("unf_coincident_cnt", {16'h0, count}, 32'hFFFF);
        bus_write(7'd3, 32'h0, 4'hF);
        bus_read(7'd4, 32'h2, "rd_err_w1c_lost");
        bus_write(7'd4, 32'h2, 4'hF);
        bus_read(7'd4, 32'h0, "rd_err_unf_clr");

        // Clear while counting, byte-strobe gating, clear beats load
        bus_write(7'd3, 32'h1, 4'hF);
        bus_write(7'd2, 32'h00FF_0002, 4'hF);
        tick_check("cnt_0100", 16'h0100);
        bus_write(7'd2, 32'h0000_0001, 4'hF);
        check("clr_no_step", {16'h0, count}, 32'h0);
        tick_check("after_clr", 16'h0001);
        bus_write(7'd3, 32'h0, 4'hF);
        check("stopped_at_2", {16'h0, count}, 32'h2);
        bus_write(7'd2, 32'h5555_0002, 4'b0011);
        check("bytestb_no_load", {16'h0, count}, 32'h2);
        bus_write(7'd2, 32'h7777_0003, 4'hF);
        check("clr_beats_load", {16'h0, count}, 32'h0);

`ifdef AL4S3B_CNT_PRESCALE_EN
        // Prescale: one step every PRESCALE+1 enabled clocks
        bus_write(7'd6, 32'h3, 4'hF);
        bus_read(7'd6, 32'h3, "rd_prescale");
        bus_write(7'd3, 32'h1, 4'hF);
        repeat (2) @(posedge clk);
        tick_check("pre_hold3", 16'h0000);
        tick_check("pre_step1", 16'h0001);
        repeat (3) @(posedge clk);
        tick_check("pre_step2", 16'h0002);
        bus_write(7'd3, 32'h0, 4'hF);
        bus_write(7'd2, 32'h0000_0001, 4'hF);
`else
        bus_read(7'd6, DFLT_RD, "rd_addr6_default");
`endif

        // Reset during the ACK cycle
        bus_write(7'd2, 32'h0ABC_0002, 4'hF);
        bus_write(7'd3, 32'h1, 4'hF);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 7'd7; wdat = 32'h1; bs = 4'hF;
        @(posedge clk); #1;
        check("pre_rst_ack", {31'h0, ack}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_async_ack", {31'h0, ack}, 32'h0);
        check("rst_async_count", {16'h0, count}, 32'h0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        bus_read(7'd3, 32'h0, "rd_en_after_rst");
        bus_read(7'd5, 32'h0, "rd_cnt_after_rst");

        repeat (3) @(posedge clk);
        check("sb_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
